// File: rtl/cv32e41p_obi_sram_bridge_if.sv
// rtl/cv32e41p_obi_sram_bridge_if.sv - OBI request/response bus between core and SRAM bridge
interface cv32e41p_obi_sram_bridge_if;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;

    // Core side drives the request phase and receives grant/response.
    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o
    );

    // Bridge side.
    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o
    );
endinterface

// File: rtl/cv32e41p_obi_sram_bridge.sv
// rtl/cv32e41p_obi_sram_bridge.sv - OBI to single-cycle SRAM bridge with fixed-latency in-order responses
module cv32e41p_obi_sram_bridge #(
    parameter int ADDR_WIDTH      = 14,
    parameter int RESP_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cv32e41p_obi_sram_bridge_if.slave obi,
    input  logic                  stall_i,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    logic [2:0]  cnt_q;
    logic        gnt;
    logic        rsp_valid;
    logic        acc_valid_q;
    logic        acc_write_q;
    logic        unused_addr;

    // Grant uses only the registered count, so a slot freed this cycle is reusable next cycle.
    assign gnt = obi.obi_req_i & ~stall_i & ~rst_i & (cnt_q < 3'(MAX_OUTSTANDING));

    assign obi.obi_gnt_o = gnt;
    assign sram_req_o    = gnt;
    assign sram_we_o     = obi.obi_we_i;
    assign sram_be_o     = obi.obi_be_i;
    assign sram_wdata_o  = obi.obi_wdata_i;
    assign sram_addr_o   = obi.obi_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr   = ^{obi.obi_addr_i[31:ADDR_WIDTH+2], obi.obi_addr_i[1:0]};

    // Outstanding transaction count: up on grant, down on response, hold when both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (gnt && !rsp_valid) begin
            cnt_q <= cnt_q + 3'd1;
        end else if (!gnt && rsp_valid) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Marks the cycle in which the SRAM read data for a granted access is on sram_rdata_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_valid_q <= 1'b0;
            acc_write_q <= 1'b0;
        end else begin
            acc_valid_q <= gnt;
            acc_write_q <= gnt & obi.obi_we_i;
        end
    end

    generate
        if (RESP_LATENCY == 1) begin : g_direct
            assign rsp_valid       = acc_valid_q;
            assign obi.obi_rdata_o = (acc_valid_q && !acc_write_q) ? sram_rdata_i : 32'h0;
        end else begin : g_pipe
            logic [RESP_LATENCY-1:1] pv_q;
            logic [RESP_LATENCY-1:1] pw_q;
            logic [31:0]             pd_q [RESP_LATENCY-1:1];

            // Delay line of {valid, is_write, data}; writes carry zero data.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pv_q <= '0;
                    pw_q <= '0;
                    for (int k = 1; k < RESP_LATENCY; k++) begin
                        pd_q[k] <= 32'h0;
                    end
                end else begin
                    pv_q[1] <= acc_valid_q;
                    pw_q[1] <= acc_write_q;
                    pd_q[1] <= (acc_valid_q && !acc_write_q) ? sram_rdata_i : 32'h0;
                    for (int k = 2; k < RESP_LATENCY; k++) begin
                        pv_q[k] <= pv_q[k-1];
                        pw_q[k] <= pw_q[k-1];
                        pd_q[k] <= pd_q[k-1];
                    end
                end
            end

            assign rsp_valid       = pv_q[RESP_LATENCY-1];
            assign obi.obi_rdata_o = (pv_q[RESP_LATENCY-1] && !pw_q[RESP_LATENCY-1]) ?
                                     pd_q[RESP_LATENCY-1] : 32'h0;
        end
    endgenerate

    assign obi.obi_rvalid_o = rsp_valid;

endmodule

// File: tb/tb_cv32e41p_obi_sram_bridge.sv
// tb/tb_cv32e41p_obi_sram_bridge.sv - scoreboard bench for three bridge configurations
module tb_cv32e41p_obi_sram_bridge;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [2:0]        req, we, stall, gnt, rvalid, sreq, swe;
    logic [2:0][31:0]  addr, wdata, rdata, srd, swd, exp_cur;
    logic [2:0][3:0]   be, sbe;
    logic [2:0][13:0]  saddr;
    logic [31:0]       mem [3][16384];
    int                lat [3] = '{1, 3, 2};
    rsp_t              q [3][$];
    rsp_t              r;
    logic [5:0]        pat;

    cv32e41p_obi_sram_bridge_if if0 ();
    cv32e41p_obi_sram_bridge_if if1 ();
    cv32e41p_obi_sram_bridge_if if2 ();

    assign if0.obi_req_i = req[0];  assign if0.obi_addr_i = addr[0];  assign if0.obi_we_i = we[0];
    assign if0.obi_be_i  = be[0];   assign if0.obi_wdata_i = wdata[0];
    assign if1.obi_req_i = req[1];  assign if1.obi_addr_i = addr[1];  assign if1.obi_we_i = we[1];
    assign if1.obi_be_i  = be[1];   assign if1.obi_wdata_i = wdata[1];
    assign if2.obi_req_i = req[2];  assign if2.obi_addr_i = addr[2];  assign if2.obi_we_i = we[2];
    assign if2.obi_be_i  = be[2];   assign if2.obi_wdata_i = wdata[2];
    assign gnt    = {if2.obi_gnt_o, if1.obi_gnt_o, if0.obi_gnt_o};
    assign rvalid = {if2.obi_rvalid_o, if1.obi_rvalid_o, if0.obi_rvalid_o};
    assign rdata  = {if2.obi_rdata_o, if1.obi_rdata_o, if0.obi_rdata_o};

    cv32e41p_obi_sram_bridge #(.ADDR_WIDTH(14), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
        .clk_i(clk), .rst_i(rst), .obi(if0), .stall_i(stall[0]),
        .sram_req_o(sreq[0]), .sram_we_o(swe[0]), .sram_be_o(sbe[0]),
        .sram_addr_o(saddr[0]), .sram_wdata_o(swd[0]), .sram_rdata_i(srd[0]));
    cv32e41p_obi_sram_bridge #(.ADDR_WIDTH(14), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u1 (
        .clk_i(clk), .rst_i(rst), .obi(if1), .stall_i(stall[1]),
        .sram_req_o(sreq[1]), .sram_we_o(swe[1]), .sram_be_o(sbe[1]),
        .sram_addr_o(saddr[1]), .sram_wdata_o(swd[1]), .sram_rdata_i(srd[1]));
    cv32e41p_obi_sram_bridge #(.ADDR_WIDTH(14), .RESP_LATENCY(2), .MAX_OUTSTANDING(2)) u2 (
        .clk_i(clk), .rst_i(rst), .obi(if2), .stall_i(stall[2]),
        .sram_req_o(sreq[2]), .sram_we_o(swe[2]), .sram_be_o(sbe[2]),
        .sram_addr_o(saddr[2]), .sram_wdata_o(swd[2]), .sram_rdata_i(srd[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: registered read (old data on a write cycle), byte-masked write.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sreq[i]) begin
                srd[i] <= mem[i][saddr[i]];
                if (swe[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sbe[i][b]) mem[i][saddr[i]][8*b +: 8] <= swd[i][8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on grant, pop and compare on rvalid, idle rdata must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && gnt[i]) q[i].push_back('{cyc + lat[i], exp_cur[i]});
                if (rvalid[i]) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("unexpected_rvalid%0d", i), 32'd1, 32'd0);
                    end else begin
                        r = q[i].pop_front();
                        check($sformatf("rvalid_cycle%0d", i), 32'(cyc), 32'(r.due));
                        check($sformatf("rdata%0d", i), rdata[i], r.data);
                    end
                end else begin
                    check($sformatf("idle_rdata%0d", i), rdata[i], 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rq, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd, input logic [31:0] e);
        req[i]     = rq;
        addr[i]    = a;
        we[i]      = w;
        be[i]      = b;
        wdata[i]   = wd;
        exp_cur[i] = e;
    endtask

    initial begin
        mem[0][5]  = 32'hCAFE_F00D;
        mem[0][8]  = 32'hFFFF_FFFF;
        mem[0][1]  = 32'hA5A5_0001;
        mem[1][16] = 32'h0000_1600;
        mem[2][3]  = 32'h3333_3333;
        req = '0; we = '0; stall = '0; addr = '0; wdata = '0; be = '0; exp_cur = '0;

        // Reset: grant suppressed, outputs cleared
        tick(); drive(0, 1, 32'h14, 0, 4'hF, 0, 0);
        @(negedge clk);
        check("rst_gnt", 32'(gnt[0]), 0);
        check("rst_sram_req", 32'(sreq[0]), 0);
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_rvalid", 32'(rvalid[i]), 0);
            check("rst_rdata", rdata[i], 0);
        end
        tick(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0);

        // Single read at 0x14
        tick(); drive(0, 1, 32'h14, 0, 4'hF, 0, 32'hCAFE_F00D);
        @(negedge clk);
        check("rd_gnt", 32'(gnt[0]), 1);
        check("rd_sram_req", 32'(sreq[0]), 1);
        check("rd_sram_addr", 32'(saddr[0]), 5);
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Partial write then back-to-back read of the same word
        tick(); drive(0, 1, 32'h20, 1, 4'b0011, 32'h1234_5678, 32'h0);
        @(negedge clk);
        check("wr_gnt", 32'(gnt[0]), 1);
        check("wr_sram_we", 32'(swe[0]), 1);
        check("wr_sram_be", 32'(sbe[0]), 32'h3);
        check("wr_sram_wdata", swd[0], 32'h1234_5678);
        check("wr_sram_addr", 32'(saddr[0]), 8);
        tick(); drive(0, 1, 32'h20, 0, 4'hF, 0, 32'hFFFF_5678);
        @(negedge clk);
        check("rbw_gnt", 32'(gnt[0]), 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Address wrap
        tick(); drive(0, 1, 32'h0001_0004, 0, 4'hF, 0, 32'hA5A5_0001);
        @(negedge clk);
        check("wrap_gnt", 32'(gnt[0]), 1);
        check("wrap_addr", 32'(saddr[0]), 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Stall with an earlier read in flight; address changes while ungranted
        tick(); drive(0, 1, 32'h14, 0, 4'hF, 0, 32'hCAFE_F00D);
        @(negedge clk);
        check("pre_stall_gnt", 32'(gnt[0]), 1);
        for (int k = 0; k < 3; k++) begin
            tick(); stall[0] = 1'b1; drive(0, 1, 32'h100 + 32'(k * 4), 0, 4'hF, 0, 32'hDEAD_BEEF);
            @(negedge clk);
            check("stall_gnt", 32'(gnt[0]), 0);
            check("stall_sram_req", 32'(sreq[0]), 0);
        end
        tick(); stall[0] = 1'b0; drive(0, 1, 32'h0001_0004, 0, 4'hF, 0, 32'hA5A5_0001);
        @(negedge clk);
        check("post_stall_gnt", 32'(gnt[0]), 1);
        check("post_stall_addr", 32'(saddr[0]), 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Outstanding limit, latency 3, two slots
        pat = 6'b110011;
        tick(); drive(1, 1, 32'h40, 0, 4'hF, 0, 32'h0000_1600);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            check($sformatf("limit_gnt_T%0d", k), 32'(gnt[1]), 32'(pat[5-k]));
        end
        tick(); drive(1, 0, 0, 0, 0, 0, 0);
        repeat (6) tick();

        // Reset while a latency-2 read is in flight
        tick(); drive(2, 1, 32'h0C, 0, 4'hF, 0, 32'h3333_3333);
        @(negedge clk);
        check("flight_gnt", 32'(gnt[2]), 1);
        tick(); rst = 1'b1;
        for (int i = 0; i < 3; i++) q[i].delete();
        @(negedge clk);
        check("midrst_gnt", 32'(gnt[2]), 0);
        check("midrst_sram_req", 32'(sreq[2]), 0);
        tick(); rst = 1'b0; drive(2, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("discard_rvalid_T2", 32'(rvalid[2]), 0);
        tick();
        @(negedge clk);
        check("discard_rvalid_T3", 32'(rvalid[2]), 0);
        tick(); drive(2, 1, 32'h0C, 0, 4'hF, 0, 32'h3333_3333);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            check($sformatf("postrst_gnt_T%0d", k), 32'(gnt[2]), (k < 2) ? 32'd1 : 32'd0);
        end
        tick(); drive(2, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        for (int i = 0; i < 3; i++) check($sformatf("drained%0d", i), 32'(q[i].size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cv32e41p_obi_sram_bridge.md
CV32E41P_OBI_SRAM_BRIDGE -- requirements
Module: cv32e41p_obi_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, SRAM word-address width (16 KWords).
REQ-002 SHALL have parameter RESP_LATENCY, default 1, cycles from grant to rvalid; legal range 1..4.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered transactions; legal range 1..4.
REQ-004 SHALL use one clock and a synchronous, active-high reset: ports clk_i and rst_i.
REQ-005 Ports (name, direction, width, meaning):
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- obi_req_i  in  1  OBI request from core (instr_req_o or data_req_o)
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  32  byte address
- obi_we_i  in  1  write enable (tie 0 on the instruction port)
- obi_be_i  in  4  byte enables
- obi_wdata_i  in  32  write data
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  32  read data
- stall_i  in  1  wait-state injection; blocks grant while high
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write
- sram_be_o  out  4  SRAM byte enables
- sram_addr_o  out  ADDR_WIDTH  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid exactly one cycle after sram_req_o

Function
REQ-006 obi_gnt_o SHALL be combinational: obi_req_i & ~stall_i & (outstanding count < MAX_OUTSTANDING).
REQ-007 A grant SHALL occur in any cycle with obi_req_i & obi_gnt_o; sram_req_o SHALL equal obi_gnt_o in the same cycle.
REQ-008 sram_addr_o SHALL be obi_addr_i[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored (address wraps modulo SRAM size); sram_we_o, sram_be_o and sram_wdata_o SHALL be passed through from the OBI inputs.
REQ-009 A transaction granted in cycle T SHALL produce obi_rvalid_o high for exactly one cycle, at T+RESP_LATENCY.
REQ-010 Responses SHALL be returned in grant order; back-to-back grants SHALL produce back-to-back rvalid pulses.
REQ-011 SRAM read data SHALL be captured at T+1 and carried through a pipeline of RESP_LATENCY-1 register stages, each holding {valid, is_write, data}.
REQ-012 obi_rdata_o SHALL carry the SRAM word for a read response and SHALL be 0 for a write response and in any cycle with obi_rvalid_o low.
REQ-013 Outstanding counter: +1 on grant only; -1 on rvalid only; unchanged on simultaneous grant and rvalid; never exceeds MAX_OUTSTANDING and never underflows.
REQ-014 A slot freed by rvalid in cycle T SHALL NOT be usable for a grant until T+1; the grant decision uses only the registered count.
REQ-015 stall_i SHALL affect only grant; in-flight responses SHALL complete on schedule regardless of stall_i.
REQ-016 The core MAY change or drop obi_addr_i/obi_req_i while ungranted; the block SHALL latch nothing from an ungranted cycle.
REQ-017 With MAX_OUTSTANDING < RESP_LATENCY, throughput SHALL be limited to MAX_OUTSTANDING grants per RESP_LATENCY+1 cycles with no lost response.

Reset
REQ-018 While rst_i is high at a clk_i edge, the outstanding count, all pipeline valid bits and pipeline data SHALL clear to 0; obi_rvalid_o = 0 and obi_rdata_o = 0 from the following cycle.
REQ-019 During reset, obi_gnt_o and sram_req_o SHALL be forced to 0.
REQ-020 Transactions in flight when reset asserts SHALL be discarded; no rvalid SHALL appear for them after reset deasserts.

Verification
REQ-021 Single read, RESP_LATENCY=1: SRAM word 5 = 0xCAFE_F00D; read at addr 0x14 -> gnt same cycle, sram_addr_o=5, rvalid at T+1, rdata=0xCAFE_F00D.
REQ-022 Write then read: write 0x1234_5678 with be=4'b0011 to 0x20, then read 0x20 over an old value of 0xFFFF_FFFF -> write rvalid with rdata=0; read returns 0xFFFF_5678.
REQ-023 Outstanding limit, RESP_LATENCY=3, MAX_OUTSTANDING=2: req held high 6 cycles -> grants at T, T+1; none at T+2, T+3; rvalids at T+3, T+4; next grant at T+4.
REQ-024 Stall: stall_i high for 3 cycles with req high -> gnt low for those 3 cycles, first grant on the cycle stall_i falls, earlier in-flight rvalid not delayed.
REQ-025 Address wrap, ADDR_WIDTH=14: read 0x0001_0004 -> sram_addr_o=1.
REQ-026 Reset mid-flight, RESP_LATENCY=2: grant at T, rst_i high at T+1 -> no rvalid at T+2 or later; count = 0; first post-reset grant returns correct data.
